// File: rtl/prog_interval_timer.sv
// Programmable interval timer: runtime period and prescaler, one-shot or periodic
// operation, pause via enable, explicit start/stop, count readback and expiry tally.
module prog_interval_timer #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8,
  parameter int EXP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic               time_out,
  output logic               busy,
  output logic [CNT_W-1:0]   count,
  output logic [EXP_W-1:0]   expiry_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [EXP_W-1:0]   EXP_ONE   = EXP_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   per_q;
  logic [PRESC_W-1:0] presc_lim_q;
  logic               mode_q;
  logic [CNT_W-1:0]   count_q;
  logic [PRESC_W-1:0] presc_q;
  logic [EXP_W-1:0]   exp_q;
  logic               to_q;

  logic start_ok;
  logic running;
  logic tick;
  logic expire;

  // A start with a zero period is treated as if it never happened.
  assign start_ok = start && !stop && (period != '0);
  assign running  = (state == RUN) && enable;
  assign tick     = running && (presc_q == presc_lim_q);
  assign expire   = tick && (count_q == (per_q - CNT_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop beats start, and a (re)start beats a coincident expiry.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start_ok) begin
      state_nxt = RUN;
    end else if (expire && !mode_q) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    busy       = (state == RUN);
    time_out   = to_q;
    count      = count_q;
    expiry_cnt = exp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q       <= '0;
      presc_lim_q <= '0;
      mode_q      <= 1'b0;
      count_q     <= '0;
      presc_q     <= '0;
      exp_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (stop) begin
        count_q <= '0;
        presc_q <= '0;
      end else if (start_ok) begin
        per_q       <= period;
        presc_lim_q <= prescale;
        mode_q      <= periodic;
        count_q     <= '0;
        presc_q     <= '0;
      end else if (running) begin
        if (tick) begin
          presc_q <= '0;
          if (expire) begin
            count_q <= '0;
            to_q    <= 1'b1;
            exp_q   <= exp_q + EXP_ONE;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end else begin
          presc_q <= presc_q + PRESC_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_interval_timer.sv
// Bench for prog_interval_timer: expected pulse cycles are queued at stimulus time
// and matched cycle by cycle against time_out; a second instance uses EXP_W=2.
module tb_prog_interval_timer;

  logic        clk = 1'b0;
  logic        reset, enable, start, stop, periodic;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        time_out, busy;
  logic [15:0] count;
  logic [7:0]  expiry_cnt;
  logic        time_out2, busy2;
  logic [15:0] count2;
  logic [1:0]  expiry_cnt2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_tot = 0;
  int sb[$];

  prog_interval_timer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .prescale(prescale),
    .time_out(time_out), .busy(busy), .count(count), .expiry_cnt(expiry_cnt)
  );

  prog_interval_timer #(.CNT_W(16), .PRESC_W(8), .EXP_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .prescale(prescale),
    .time_out(time_out2), .busy(busy2), .count(count2), .expiry_cnt(expiry_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required <100000", cyc);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Issue a start at this negedge; returns the cycle index of the sampling edge E0.
  task automatic do_start(input int p, input int s, input logic m, output int e0);
    start    = 1'b1;
    period   = 16'(p);
    prescale = 8'(s);
    periodic = m;
    e0 = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
    periodic = 1'b0; period = '0; prescale = '0;
    step(); step();
    reset = 1'b0;
    tests++; if (time_out !== 1'b0) begin fails++; $display("FAIL reset_time_out got %0b want 0", time_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (expiry_cnt !== 8'd0) begin fails++; $display("FAIL reset_expiry got %0d want 0", expiry_cnt); end
    tests++; if (expiry_cnt2 !== 2'd0) begin fails++; $display("FAIL reset_expiry2 got %0d want 0", expiry_cnt2); end
    exp_tot = 0;
    step();
  endtask

  task automatic test_oneshot();
    int e0; logic exp_p;
    sb.delete();
    do_start(5, 0, 1'b0, e0);
    sb.push_back(e0 + 5);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL oneshot_busy_start got %0b want 1", busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_p = (sb.size() > 0 && sb[0] == cyc);
      if (exp_p) void'(sb.pop_front());
      tests++; if (time_out !== exp_p) begin fails++; $display("FAIL oneshot_pulse k=%0d got %0b want %0b", k, time_out, exp_p); end
      if (k == 5) begin
        exp_tot++;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL oneshot_busy_end got %0b want 0", busy); end
        tests++; if (expiry_cnt !== 8'(exp_tot)) begin fails++; $display("FAIL oneshot_expiry got %0d want %0d", expiry_cnt, exp_tot); end
      end
    end
  endtask

  task automatic test_periodic();
    int e0; logic exp_p; int want;
    sb.delete();
    do_start(3, 1, 1'b1, e0);
    for (int i = 1; i <= 4; i++) sb.push_back(e0 + 6 * i);
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) step();
      want = (k % 6) / 2;
      exp_p = (sb.size() > 0 && sb[0] == cyc);
      if (exp_p) void'(sb.pop_front());
      tests++; if (time_out !== exp_p) begin fails++; $display("FAIL periodic_pulse k=%0d got %0b want %0b", k, time_out, exp_p); end
      tests++; if (count !== 16'(want)) begin fails++; $display("FAIL periodic_count k=%0d got %0d want %0d", k, count, want); end
    end
    exp_tot += 4;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL periodic_busy got %0b want 1", busy); end
    tests++; if (expiry_cnt !== 8'(exp_tot)) begin fails++; $display("FAIL periodic_expiry got %0d want %0d", expiry_cnt, exp_tot); end
    tests++; if (expiry_cnt2 !== 2'(exp_tot)) begin fails++; $display("FAIL periodic_expiry2 got %0d want %0d", expiry_cnt2, 2'(exp_tot)); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL periodic_stop_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL periodic_stop_count got %0d want 0", count); end
  endtask

  task automatic test_pause();
    int e0; logic exp_p;
    int cnt_tbl[10];
    cnt_tbl = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
    sb.delete();
    do_start(4, 0, 1'b0, e0);
    sb.push_back(e0 + 7);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      exp_p = (sb.size() > 0 && sb[0] == cyc);
      if (exp_p) void'(sb.pop_front());
      tests++; if (time_out !== exp_p) begin fails++; $display("FAIL pause_pulse k=%0d got %0b want %0b", k, time_out, exp_p); end
      tests++; if (count !== 16'(cnt_tbl[k])) begin fails++; $display("FAIL pause_count k=%0d got %0d want %0d", k, count, cnt_tbl[k]); end
      if (k == 4) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pause_busy got %0b want 1", busy); end
      end
      if (k == 2) enable = 1'b0;
      if (k == 5) enable = 1'b1;
    end
    exp_tot++;
    tests++; if (expiry_cnt !== 8'(exp_tot)) begin fails++; $display("FAIL pause_expiry got %0d want %0d", expiry_cnt, exp_tot); end
  endtask

  task automatic test_stop();
    int e0;
    sb.delete();
    do_start(3, 0, 1'b0, e0);
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++; if (time_out !== 1'b0) begin fails++; $display("FAIL stop_at_expiry_pulse got %0b want 0", time_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_at_expiry_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL stop_at_expiry_count got %0d want 0", count); end
    do_start(5, 0, 1'b0, e0);
    step(); step();
    start = 1'b1; stop = 1'b1; period = 16'd5;
    step();
    start = 1'b0; stop = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL start_stop_count got %0d want 0", count); end
    for (int k = 0; k < 8; k++) begin
      step();
      tests++; if (time_out !== 1'b0) begin fails++; $display("FAIL start_stop_pulse k=%0d got %0b want 0", k, time_out); end
    end
    tests++; if (expiry_cnt !== 8'(exp_tot)) begin fails++; $display("FAIL stop_expiry got %0d want %0d", expiry_cnt, exp_tot); end
  endtask

  task automatic test_restart();
    int e0; logic exp_p; int want;
    sb.delete();
    do_start(10, 0, 1'b0, e0);
    for (int k = 1; k <= 20; k++) begin
      step();
      want = (k <= 7) ? k : ((k < 18) ? k - 8 : 0);
      exp_p = (sb.size() > 0 && sb[0] == cyc);
      if (exp_p) void'(sb.pop_front());
      tests++; if (time_out !== exp_p) begin fails++; $display("FAIL restart_pulse k=%0d got %0b want %0b", k, time_out, exp_p); end
      tests++; if (count !== 16'(want)) begin fails++; $display("FAIL restart_count k=%0d got %0d want %0d", k, count, want); end
      case (k)
        3: begin start = 1'b1; period = 16'd0; end
        4: begin start = 1'b0; period = 16'd2; end
        7: begin start = 1'b1; period = 16'd10; sb.push_back(cyc + 11); end
        8: begin start = 1'b0; period = 16'd3; end
        default: ;
      endcase
    end
    exp_tot++;
    start = 1'b1; period = 16'd0;
    step();
    start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_period_busy got %0b want 0", busy); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_period_busy2 got %0b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int e0;
    do_start(8, 0, 1'b0, e0);
    step(); step(); step();
    tests++; if (count !== 16'd3) begin fails++; $display("FAIL midrun_count got %0d want 3", count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_tot = 0;
    tests++; if (time_out !== 1'b0) begin fails++; $display("FAIL midrun_reset_pulse got %0b want 0", time_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL midrun_reset_count got %0d want 0", count); end
    tests++; if (expiry_cnt !== 8'd0) begin fails++; $display("FAIL midrun_reset_expiry got %0d want 0", expiry_cnt); end
  endtask

  task automatic test_wrap();
    int e0; logic exp_p;
    sb.delete();
    do_start(2, 0, 1'b1, e0);
    for (int i = 1; i <= 4; i++) sb.push_back(e0 + 2 * i);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_p = (sb.size() > 0 && sb[0] == cyc);
      if (exp_p) begin void'(sb.pop_front()); exp_tot++; end
      tests++; if (time_out2 !== exp_p) begin fails++; $display("FAIL wrap_pulse k=%0d got %0b want %0b", k, time_out2, exp_p); end
      if (k == 6) begin
        tests++; if (expiry_cnt2 !== 2'd3) begin fails++; $display("FAIL wrap_expiry2_pre got %0d want 3", expiry_cnt2); end
      end
      if (k == 8) stop = 1'b1;
    end
    step();
    stop = 1'b0;
    tests++; if (expiry_cnt2 !== 2'd0) begin fails++; $display("FAIL wrap_expiry2 got %0d want 0", expiry_cnt2); end
    tests++; if (expiry_cnt !== 8'(exp_tot)) begin fails++; $display("FAIL wrap_expiry got %0d want %0d", expiry_cnt, exp_tot); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop();
    test_restart();
    test_reset_midrun();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
